// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage.
// Optional build macro: MEM_ADDR_CHECK_EN.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_SRAM_AW     = 18;

endpackage

// File: rtl/mem_stage_sram_controller.sv
// Word access over a 16-bit async SRAM as two half-word phases.
// Build macro MEM_ADDR_CHECK_EN enables out-of-range rejection.
module sram_controller
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  output logic               o_ready,
  output logic [31:0]        o_mem_data,
  output logic               o_addr_err,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [15:0]        o_sram_dq_out,
  input  logic [15:0]        i_sram_dq_in,
  output logic               o_sram_dq_oe,
  output logic               o_sram_we_n
);

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

  state_e             r_state;
  logic [2:0]         r_cnt;
  logic [15:0]        r_lo;
  logic               r_ready;
  logic               r_addr_err;
  logic [31:0]        r_mem_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [15:0]        r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;

  logic [SRAM_AW-2:0] w_word;
  logic               w_last;
  logic               w_err;
  logic [2:0]         w_cnt_nx;

  assign w_word = (SRAM_AW-1)'(
    (i_addr - 32'(BASE_ADDR)) >> 2);
  assign w_last   = (r_cnt == LAST);
  assign w_cnt_nx = r_cnt + 3'd1;

`ifdef MEM_ADDR_CHECK_EN
  logic [31:0] w_off;
  assign w_off = i_addr - 32'(BASE_ADDR);
  assign w_err = (i_addr < 32'(BASE_ADDR))
               | (|i_addr[1:0])
               | (|w_off[31:SRAM_AW+1]);
`else
  assign w_err = 1'b0;
`endif

  // Access sequencer; every SRAM pin is registered so it is glitch-free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_lo        <= 16'd0;
      r_ready     <= 1'b0;
      r_addr_err  <= 1'b0;
      r_mem_data  <= 32'd0;
      r_sram_addr <= '0;
      r_dq_out    <= 16'd0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_req && w_err) begin
            r_state    <= S_DONE;
            r_ready    <= 1'b1;
            r_addr_err <= 1'b1;
            if (!i_we) r_mem_data <= 32'd0;
          end else if (i_req) begin
            r_state     <= S_LOW;
            r_cnt       <= 3'd0;
            r_sram_addr <= {w_word, 1'b0};
            r_dq_oe     <= i_we;
            r_we_n      <= ~i_we;
            if (i_we) r_dq_out <= i_wdata[15:0];
          end
        end
        S_LOW: begin
          if (w_last) begin
            r_state     <= S_HIGH;
            r_cnt       <= 3'd0;
            r_sram_addr <= {w_word, 1'b1};
            r_we_n      <= ~i_we;
            if (i_we) r_dq_out <= i_wdata[31:16];
            else      r_lo     <= i_sram_dq_in;
          end else begin
            r_cnt  <= w_cnt_nx;
            r_we_n <= ~i_we | (w_cnt_nx == LAST);
          end
        end
        S_HIGH: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            if (!i_we) r_mem_data <= {i_sram_dq_in, r_lo};
          end else begin
            r_cnt  <= w_cnt_nx;
            r_we_n <= ~i_we | (w_cnt_nx == LAST);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_addr_err <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready       = r_ready;
  assign o_addr_err    = r_addr_err;
  assign o_mem_data    = r_mem_data;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_dq_out;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_sram_we_n   = r_we_n;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: pass-through, stall and SRAM access wrapper.
// Build macro MEM_ADDR_CHECK_EN enables out-of-range rejection.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        val_rm,
  input  logic [3:0]         dest_in,
  output logic               wb_en,
  output logic               mem_r_en,
  output logic [31:0]        alu_result,
  output logic [31:0]        mem_data,
  output logic [3:0]         dest,
  output logic               freeze,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  logic w_req;
  logic w_ready;

  assign w_req = mem_r_en_in | mem_w_en_in;

  sram_controller #(
    .BASE_ADDR  (BASE_ADDR),
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_AW    (SRAM_AW)
  ) u_ctrl (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (w_req),
    .i_we         (mem_w_en_in),
    .i_addr       (alu_result_in),
    .i_wdata      (val_rm),
    .o_ready      (w_ready),
    .o_mem_data   (mem_data),
    .o_addr_err   (addr_err),
    .o_sram_addr  (sram_addr),
    .o_sram_dq_out(sram_dq_out),
    .i_sram_dq_in (sram_dq_in),
    .o_sram_dq_oe (sram_dq_oe),
    .o_sram_we_n  (sram_we_n)
  );

  assign wb_en      = wb_en_in;
  assign mem_r_en   = mem_r_en_in;
  assign alu_result = alu_result_in;
  assign dest       = dest_in;
  assign ready      = w_ready;
  assign freeze     = w_req & ~w_ready;

endmodule
